// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch front end
package inst_fetch_unit_pkg;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INST_W  = 32;
  localparam int DEF_PC_STEP = 4;

  // ISSUE: a request may be offered; WAIT: one request outstanding
  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_e;

  // occupancy counter width: enough to hold the value DEPTH itself
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// rtl/inst_fetch_unit_fifo.sv - synchronous fetch FIFO holding {inst, pc} entries
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_clear,
  input  logic                      i_push,
  input  logic [W-1:0]              i_push_data,
  input  logic                      i_pop,
  output logic [W-1:0]              o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // a pop frees the head slot in the same edge, so push is legal even when full
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_count;
  // empty FIFO presents zeros so the head outputs are defined after reset
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // pointer and occupancy update; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // entry storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (i_en && !i_clear && w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC, single-outstanding icache requester and fetch buffer
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                   ADDR_W    = DEF_ADDR_W,
  parameter int                   INST_W    = DEF_INST_W,
  parameter int unsigned          PC_STEP   = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int                   BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_ready,
  input  logic              ic_resp_valid,
  input  logic [INST_W-1:0] ic_resp_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              iq_full,
  output logic              iq_valid,
  output logic [INST_W-1:0] iq_inst,
  output logic [ADDR_W-1:0] iq_pc
);

  localparam int CNT_W = cnt_width(BUF_DEPTH);
  localparam int ENT_W = INST_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] w_req_pc_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic [ENT_W-1:0]  w_head;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_en        (rdy),
    .i_clear     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({ic_resp_inst, r_req_pc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign ic_req_valid = w_req_valid;
  assign ic_req_addr  = r_pc;
  assign iq_valid     = ~w_empty;
  assign iq_inst      = w_head[ENT_W-1:ADDR_W];
  assign iq_pc        = w_head[ADDR_W-1:0];
  assign w_req_fire   = w_req_valid & ic_req_ready;
  // a redirect flushes the buffer, so nothing may leave it in that cycle
  assign w_pop        = ~w_empty & ~iq_full & ~redirect_valid;

  // state, PC and drop flag; rdy=0 freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ISSUE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_drop   <= INVALID;
    end else if (rdy) begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // next-state, request offer and push decision
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    w_req_valid  = INVALID;
    w_push       = INVALID;
    case (r_state)
      ST_ISSUE: begin
        // only ask when the reply is guaranteed a free slot
        w_req_valid = ~rst & (w_count < CNT_W'(BUF_DEPTH));
        if (w_req_fire) begin
          w_state_nxt  = ST_WAIT;
          w_req_pc_nxt = r_pc;
        end
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          // the request just accepted belongs to the old stream
          if (w_req_fire) w_drop_nxt = VALID;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          if (ic_resp_valid) begin
            w_drop_nxt  = INVALID;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_drop_nxt  = VALID;
          end
        end else if (ic_resp_valid) begin
          if (!r_drop) begin
            w_push   = VALID;
            w_pc_nxt = r_req_pc + ADDR_W'(PC_STEP);
          end
          w_drop_nxt  = INVALID;
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_ISSUE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_full;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] popped[$];
  int          pop_cyc[$];

  int cache_lat    = 1;
  bit ready_toggle = 1'b0;
  int cyc          = 0;

  bit          m_en, m_redir, m_hs, m_cons, m_xfer;
  bit          pend, pstale, rstale;
  int          cd;
  logic [31:0] haddr, paddr, raddr;
  logic [31:0] h_pc, h_inst;
  ent_t        e;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_inst   (ic_resp_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iq_full        (iq_full),
    .iq_valid       (iq_valid),
    .iq_inst        (iq_inst),
    .iq_pc          (iq_pc)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // icache model and output monitor
  initial begin
    ic_req_ready  = 1'b1;
    ic_resp_valid = 1'b0;
    ic_resp_inst  = '0;
    pend = 1'b0; pstale = 1'b0; rstale = 1'b0; cd = 0;
    forever begin
      @(posedge clk);
      cyc++;
      m_en    = rdy && !rst;
      m_redir = m_en && redirect_valid;
      m_hs    = m_en && ic_req_valid && ic_req_ready;
      haddr   = ic_req_addr;
      m_cons  = m_en && ic_resp_valid;
      m_xfer  = m_en && iq_valid && !iq_full && !m_redir;
      h_pc    = iq_pc;
      h_inst  = iq_inst;
      if (m_xfer) begin
        popped.push_back(h_pc);
        pop_cyc.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_pop: got pc=%h inst=%h, required no output (scoreboard empty)", h_pc, h_inst);
        end else begin
          e = sb.pop_front();
          if (h_pc !== e.pc || h_inst !== e.inst) begin
            bad++;
            $display("FAIL sb_pop: got pc=%h inst=%h, required pc=%h inst=%h", h_pc, h_inst, e.pc, e.inst);
          end
        end
      end
      if (rst || m_redir) sb.delete();
      if (m_cons && !(rstale || m_redir)) sb.push_back({raddr, ic_resp_inst});
      #1;
      if (rst) begin
        pend = 1'b0;
        ic_resp_valid = 1'b0;
      end else if (rdy) begin
        if (m_cons) ic_resp_valid = 1'b0;
        if (m_redir) pstale = 1'b1;
        if (m_hs) begin
          pend = 1'b1; paddr = haddr; cd = cache_lat; pstale = m_redir;
        end
        if (pend) begin
          cd--;
          if (cd == 0) begin
            ic_resp_valid = 1'b1;
            ic_resp_inst  = inst_of(paddr);
            raddr  = paddr;
            rstale = pstale;
            pend   = 1'b0;
          end
        end
      end
      if (ready_toggle) ic_req_ready = ~ic_req_ready;
      else ic_req_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required self-termination");
    $fatal(1);
  end

  task automatic do_reset(input bit full, input int lat);
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; iq_full = full;
    cache_lat = lat; ready_toggle = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    popped.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    int k = 0;
    while (popped.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (popped.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; iq_full = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ic_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b required 0", ic_req_valid); end
    total++; if (ic_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h required 0", ic_req_addr); end
    total++; if (iq_valid !== 1'b0) begin bad++; $display("FAIL rst_iq_valid: got %b required 0", iq_valid); end
    total++; if (iq_inst !== 32'h0) begin bad++; $display("FAIL rst_iq_inst: got %h required 0", iq_inst); end
    total++; if (iq_pc !== 32'h0) begin bad++; $display("FAIL rst_iq_pc: got %h required 0", iq_pc); end
    rst = 1'b0;
    #1;
    total++; if (ic_req_valid !== 1'b1) begin bad++; $display("FAIL rst_first_req: got %b required 1", ic_req_valid); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] exp_pc;
    do_reset(1'b0, 1);
    wait_pops(4, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL seq_timeout: got %0d pops required 4", popped.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        exp_pc = 32'(i * 4);
        total++;
        if (popped[i] !== exp_pc) begin bad++; $display("FAIL seq_pc%0d: got %h required %h", i, popped[i], exp_pc); end
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pop_cyc[i+1] - pop_cyc[i] !== 2) begin
          bad++; $display("FAIL seq_rate%0d: got gap %0d required 2", i, pop_cyc[i+1] - pop_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_pc;
    do_reset(1'b1, 1);
    repeat (20) @(negedge clk);
    total++; if (ic_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid: got %b required 0", ic_req_valid); end
    total++; if (iq_valid !== 1'b1 || iq_pc !== 32'h0 || iq_inst !== inst_of(32'h0)) begin
      bad++; $display("FAIL bp_head: got v=%b pc=%h inst=%h required v=1 pc=0 inst=%h", iq_valid, iq_pc, iq_inst, inst_of(32'h0));
    end
    total++; if (popped.size() !== 0) begin bad++; $display("FAIL bp_no_pop: got %0d pops required 0", popped.size()); end
    iq_full = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (popped.size() !== 4) begin bad++; $display("FAIL bp_drain: got %0d pops required 4", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      total++;
      if (popped[i] !== exp_pc) begin bad++; $display("FAIL bp_pc%0d: got %h required %h", i, popped[i], exp_pc); end
    end
    wait_pops(5, 40, ok);
    total++; if (!ok || popped[4] !== 32'h10) begin bad++; $display("FAIL bp_resume: got %h required 00000010", popped[4]); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int k;
    do_reset(1'b0, 3);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (iq_valid !== 1'b0 || ic_req_valid !== 1'b0) begin
      bad++; $display("FAIL rdw_after: got iq_valid=%b req_valid=%b required 0 0", iq_valid, ic_req_valid);
    end
    k = 0;
    while (ic_req_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100) begin
      bad++; $display("FAIL rdw_req: got valid=%b addr=%h required 1 00000100", ic_req_valid, ic_req_addr);
    end
    wait_pops(2, 40, ok);
    total++; if (!ok || popped[0] !== 32'h100) begin bad++; $display("FAIL rdw_pc0: got %h required 00000100", popped[0]); end
    total++; if (!ok || popped[1] !== 32'h104) begin bad++; $display("FAIL rdw_pc1: got %h required 00000104", popped[1]); end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    int k;
    do_reset(1'b1, 2);
    k = 0;
    while (!(ic_resp_valid === 1'b1 && iq_valid === 1'b1) && k < 40) begin @(negedge clk); k++; end
    total++; if (k >= 40) begin bad++; $display("FAIL rdc_setup: got timeout required resp with buffered entry"); end
    iq_full = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0; iq_full = 1'b1;
    total++; if (popped.size() !== 0) begin bad++; $display("FAIL rdc_no_pop: got %0d pops required 0", popped.size()); end
    total++; if (iq_valid !== 1'b0) begin bad++; $display("FAIL rdc_empty: got iq_valid=%b required 0", iq_valid); end
    total++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h200) begin
      bad++; $display("FAIL rdc_req: got valid=%b addr=%h required 1 00000200", ic_req_valid, ic_req_addr);
    end
    iq_full = 1'b0;
    wait_pops(1, 40, ok);
    total++; if (!ok || popped[0] !== 32'h200) begin bad++; $display("FAIL rdc_pc0: got %h required 00000200", popped[0]); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(1'b0, 4);
    wait_pops(2, 60, ok);
    total++; if (!ok || ic_req_valid !== 1'b0 || ic_req_addr !== 32'h8 || iq_valid !== 1'b0) begin
      bad++; $display("FAIL stall_pre: got req_valid=%b addr=%h iq_valid=%b required 0 00000008 0", ic_req_valid, ic_req_addr, iq_valid);
    end
    rdy = 1'b0; ready_toggle = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      total++;
      if (ic_req_valid !== 1'b0 || ic_req_addr !== 32'h8 || iq_valid !== 1'b0 || iq_pc !== 32'h0) begin
        bad++; $display("FAIL stall_hold%0d: got req_valid=%b addr=%h iq_valid=%b iq_pc=%h required 0 00000008 0 0", i, ic_req_valid, ic_req_addr, iq_valid, iq_pc);
      end
    end
    rdy = 1'b1;
    wait_pops(4, 80, ok);
    total++; if (!ok || popped[2] !== 32'h8) begin bad++; $display("FAIL stall_pc2: got %h required 00000008", popped[2]); end
    total++; if (!ok || popped[3] !== 32'hC) begin bad++; $display("FAIL stall_pc3: got %h required 0000000c", popped[3]); end
    ready_toggle = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1'b0, 1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pops(2, 40, ok);
    total++; if (!ok || popped[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc0: got %h required fffffffc", popped[0]); end
    total++; if (!ok || popped[1] !== 32'h0) begin bad++; $display("FAIL wrap_pc1: got %h required 00000000", popped[1]); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collide();
    test_stall();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
